// File: rtl/adder_ctrl_pkg.sv
// Shared types and defaults for the shared-adder controller.
// Result-slot state plus default sizing constants.
package adder_ctrl_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int WIDTH_DEF   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches req from ptr upward, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// One unsigned adder shared by NUM_REQ requesters under round-robin.
// Single registered result slot tagged with the requester index.
module adder_share_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int CNT_W   = 16,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH:0]           res_sum,
    output logic [ID_W-1:0]          res_id,
    output logic [CNT_W-1:0]         op_count
);

    state_e state_q, state_d;

    logic [ID_W-1:0]    ptr_q;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gidx;
    logic               any;
    logic               accept;
    logic               xfer;
    logic               drain;
    logic [WIDTH-1:0]   a_g;
    logic [WIDTH-1:0]   b_g;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .req      (req_valid),
        .ptr      (ptr_q),
        .grant    (gnt),
        .grant_idx(gidx),
        .any      (any)
    );

    assign res_valid = (state_q == FULL);
    assign accept    = !res_valid || res_ready;
    assign req_ready = accept ? gnt : '0;
    assign xfer      = any && accept;
    assign drain     = res_valid && res_ready;
    assign a_g       = req_a[gidx*WIDTH +: WIDTH];
    assign b_g       = req_b[gidx*WIDTH +: WIDTH];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (xfer) state_d = FULL;
            FULL:  if (res_ready && !xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands are only captured on a handshake; otherwise the slot holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum <= '0;
            res_id  <= '0;
            ptr_q   <= '0;
        end else if (xfer) begin
            res_sum <= {1'b0, a_g} + {1'b0, b_g};
            res_id  <= gidx;
            ptr_q   <= (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (drain && (op_count != '1)) begin
            op_count <= op_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Randomized and directed bench for adder_share_ctrl.
// Reference model works at transaction level in plain integers.
module tb_adder_share_ctrl;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int CW = 4;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           res_valid;
    logic           res_ready;
    logic [W:0]     res_sum;
    logic [1:0]     res_id;
    logic [CW-1:0]  op_count;

    int checks;
    int errors;

    int m_valid, m_sum, m_id, m_cnt, m_ptr;

    adder_share_ctrl #(
        .NUM_REQ(N),
        .WIDTH  (W),
        .CNT_W  (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_ready(req_ready),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_sum  (res_sum),
        .res_id   (res_id),
        .op_count (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_sum   = 0;
        m_id    = 0;
        m_cnt   = 0;
        m_ptr   = 0;
    endtask

    // Called at posedge+1 with inputs already driven; ends at next posedge+1.
    task automatic cycle(input string tag);
        int g;
        int acc;
        int xf;
        int dr;
        int exp_rdy;
        int va, vb;
        #4;
        g = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (g < 0 && req_valid[j]) g = j;
        end
        acc = (!m_valid || res_ready) ? 1 : 0;
        xf  = (g >= 0 && acc != 0) ? 1 : 0;
        dr  = (m_valid != 0 && res_ready) ? 1 : 0;
        exp_rdy = xf ? (1 << g) : 0;
        chk({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
        va = 0;
        vb = 0;
        if (xf) begin
            va = int'((req_a >> (g * W)) & 16'hF);
            vb = int'((req_b >> (g * W)) & 16'hF);
        end
        @(posedge clk);
        #1;
        if (dr && m_cnt < (1 << CW) - 1) m_cnt++;
        if (xf) begin
            m_valid = 1;
            m_sum   = va + vb;
            m_id    = g;
            m_ptr   = (g + 1) % N;
        end else if (dr) begin
            m_valid = 0;
        end
        chk({tag, ".valid"}, 32'(res_valid), 32'(m_valid));
        chk({tag, ".sum"}, 32'(res_sum), 32'(m_sum));
        chk({tag, ".id"}, 32'(res_id), 32'(m_id));
        chk({tag, ".cnt"}, 32'(op_count), 32'(m_cnt));
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*W +: W] = W'(a);
        req_b[i*W +: W] = W'(b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        rst_n     = 1'b0;
        model_reset();
        #2;
        chk("rst.valid", 32'(res_valid), 0);
        chk("rst.sum", 32'(res_sum), 0);
        chk("rst.id", 32'(res_id), 0);
        chk("rst.cnt", 32'(op_count), 0);
        chk("rst.ready", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single request
        req_valid = 4'b0001;
        set_op(0, 2, 13);
        cycle("single");
        chk("single.sum15", 32'(res_sum), 32'd15);
        req_valid = '0;
        res_ready = 1'b1;
        cycle("drain");
        chk("drain.cnt1", 32'(op_count), 1);

        // carry cases on requester 2
        req_valid = 4'b0100;
        set_op(2, 15, 1);
        cycle("carry1");
        chk("carry1.sum", 32'(res_sum), 32'h10);
        chk("carry1.id", 32'(res_id), 2);
        set_op(2, 10, 7);
        cycle("carry2");
        chk("carry2.sum", 32'(res_sum), 32'h11);

        // fairness from a fresh pointer
        req_valid = '0;
        do_reset();
        req_valid = 4'b1111;
        res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_a = 16'($urandom);
            req_b = 16'($urandom);
            cycle("rr");
            chk("rr.seq", 32'(res_id), 32'(i % N));
        end

        // backpressure
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_a = 16'($urandom);
            req_b = 16'($urandom);
            cycle("bp");
            chk("bp.ready0", 32'(req_ready), 0);
        end
        res_ready = 1'b1;
        cycle("bp.release");

        // reset mid-operation
        req_valid = '0;
        do_reset();
        req_valid = 4'b0010;
        res_ready = 1'b0;
        cycle("pre_rst");
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.valid", 32'(res_valid), 0);
        chk("midrst.sum", 32'(res_sum), 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 4'b1111;
        res_ready = 1'b1;
        cycle("post_rst");
        chk("post_rst.id0", 32'(res_id), 0);

        // saturation
        for (int i = 0; i < 20; i++) begin
            req_a = 16'($urandom);
            req_b = 16'($urandom);
            cycle("sat");
        end
        chk("sat.max", 32'(op_count), 32'hF);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            req_valid = N'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            res_ready = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end
        chk("rand.sat", 32'(op_count), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
